urp_pcie_crc32_arb: RTL and testbench
=====================================

# urp_pcie_crc32_arb

Round-robin arbiter and sequencer that shares one CRC32 encoder between several TLP sources on the PCIe transmit path. It accepts one DATA_WIDTH beat per cycle from the granted requester and drives the encoder's valid/data inputs. It tags each beat with the requester ID, realigned to the encoder's 1-cycle latency, and buffers data+checksum+ID in a 4-entry output FIFO with valid/ready backpressure. The encoder has no stall input, so the block issues beats on a credit basis and never overruns the FIFO.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 224, payload width per beat
- CRC_WIDTH, 32, checksum width
- ID_WIDTH, $clog2(NUM_REQ), requester ID width
- FIFO_DEPTH, 4, output FIFO entries (fixed, power of 2)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_data_i  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  NUM_REQ  one-hot grant/accept
- enc_valid_o  out  1  to encoder valid_i
- enc_data_o  out  DATA_WIDTH  to encoder data_i
- enc_valid_i  in  1  from encoder valid_o
- enc_data_i  in  DATA_WIDTH  from encoder data_o
- enc_checksum_i  in  CRC_WIDTH  from encoder checksum_o
- out_valid_o  out  1  FIFO head valid
- out_data_o  out  DATA_WIDTH  head payload
- out_crc_o  out  CRC_WIDTH  head checksum
- out_id_o  out  ID_WIDTH  head requester ID
- out_ready_i  in  1  downstream accept
- err_o  out  1  sticky: encoder result with no matching issue, or FIFO overflow

## Operation
- Credits: issue_ok = (fifo_count + inflight) < FIFO_DEPTH.
  - inflight = enc_valid_o + id_valid_d1, range 0..2.
  - A pop in the current cycle does not return a credit until the next cycle.
- Arbitration:
  - Runs only when issue_ok.
  - Search starts at last_grant+1 mod NUM_REQ and picks the first requester with req_valid_i=1.
  - req_ready_o is combinational and one-hot at that index; all zeros when !issue_ok or no valid request.
  - A handshake is req_valid_i[i] & req_ready_o[i]; last_grant updates only on a handshake.
- Stage 1 registers: enc_valid_o <= handshake; enc_data_o <= granted data (held when no handshake); id_s1 <= granted index.
- Stage 2 registers: id_valid_d1 <= enc_valid_o; id_d1 <= id_s1. These match the encoder's 1-cycle latency.
- FIFO push when enc_valid_i=1.
  - Entry = {enc_data_i, enc_checksum_i, id_d1}.
  - enc_valid_i=1 with id_valid_d1=0: err_o set, entry still pushed with ID 0.
  - Push when fifo_count==FIFO_DEPTH: err_o set, beat dropped, count unchanged.
- FIFO pop when out_valid_o & out_ready_i. Simultaneous push and pop leaves the count unchanged, including when full.
- Outputs come from the head register. out_valid_o = (fifo_count != 0). Output data is undefined (don't-care) when out_valid_o=0.
- err_o clears only on reset.

## Timing
- Reset values: req_ready_o=0, enc_valid_o=0, enc_data_o=0, id_valid_d1=0, fifo_count=0, out_valid_o=0, err_o=0. last_grant=NUM_REQ-1, so requester 0 has first priority.
- Latency: handshake in cycle t, then enc_valid_o in t+1, enc_valid_i in t+2 (pushed at the end of t+2), out_valid_o in t+3. Minimum latency is 3 cycles.
- Throughput: 1 beat/cycle while out_ready_i is held high.
- Backpressure: with out_ready_i=0, exactly FIFO_DEPTH beats are accepted, after which req_ready_o stays 0. Acceptance resumes the cycle after the first pop.
- Reset mid-operation: in-flight beats and FIFO contents are discarded. The encoder's own reset is expected on the same rst_n.
- A requester that deasserts valid without a handshake loses no fairness state.

## Test plan
- Single beat: req_valid_i=0001 with data D, out_ready_i=1. Expect out_valid_o in cycle t+3 with out_data_o=D, out_crc_o=CRC32(D), out_id_o=0, err_o=0.
- Fairness: all four requesters valid continuously for 8 cycles. Expect grants in order 0,1,2,3,0,1,2,3 and out_id_o in the same order at 1 beat/cycle.
- Backpressure: out_ready_i=0, all requesters valid. Expect exactly 4 handshakes, then req_ready_o=0000 held. Raise out_ready_i for 1 cycle: exactly one new grant, to the next RR index, in the following cycle.
- Full with simultaneous push/pop: keep the FIFO at 4 with out_ready_i toggling 1/0. Expect no loss, fifo_count never exceeding 4, err_o=0.
- Spurious result: drive enc_valid_i=1 while the block is idle. Expect err_o=1 from the next cycle, sticky until rst_n.
- Reset mid-stream: assert rst_n=0 asynchronously while beats are in flight. Expect all outputs at reset values immediately, no stale out_valid_o after release, and the first grant after release going to requester 0.

Source files
------------

// File: rtl/urp_pcie_crc32_arb.sv
`default_nettype none
// ============================================================================
// Module      : urp_pcie_crc32_arb
// Description : Round-robin arbiter that shares one CRC32 encoder between
//               several TLP sources. Beats are issued on a credit basis so the
//               4-entry result FIFO (data + checksum + requester ID) never
//               overruns, because the encoder itself cannot be stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module urp_pcie_crc32_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 224,
    parameter int CRC_WIDTH  = 32,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          enc_valid_o,
    output logic [DATA_WIDTH-1:0]         enc_data_o,
    input  logic                          enc_valid_i,
    input  logic [DATA_WIDTH-1:0]         enc_data_i,
    input  logic [CRC_WIDTH-1:0]          enc_checksum_i,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [CRC_WIDTH-1:0]          out_crc_o,
    output logic [ID_WIDTH-1:0]           out_id_o,
    input  logic                          out_ready_i,
    output logic                          err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH:0]     cand;
    logic                  grant_found;
    logic                  issue_ok;
    logic                  handshake;
    logic [CNT_W:0]        credit_use;
    logic [ID_WIDTH-1:0]   id_s1;
    logic                  id_valid_d1;
    logic [ID_WIDTH-1:0]   id_d1;

    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  fifo_full;
    logic                  pop;
    logic                  push_ok;
    logic                  overflow;
    logic                  orphan;
    logic [ID_WIDTH-1:0]   push_id;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [CRC_WIDTH-1:0]  mem_crc  [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   mem_id   [FIFO_DEPTH];

    // Slice the flat requester bus into one word per requester
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign req_data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Every beat either sits in the FIFO or is still travelling through the
    // encoder (one or two stages); all of them hold a FIFO slot.
    assign credit_use = {1'b0, fifo_count}
                      + {{CNT_W{1'b0}}, enc_valid_o}
                      + {{CNT_W{1'b0}}, id_valid_d1};
    assign issue_ok   = credit_use < (CNT_W+1)'(FIFO_DEPTH);

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (ID_WIDTH+1)'(k);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[cand[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    assign handshake   = grant_found & issue_ok;
    // Gated by rst_n so the combinational grant is quiet while in reset
    assign req_ready_o = (handshake && rst_n) ? (NUM_REQ'(1) << grant_idx) : '0;

    // Issue stage and ID realignment pipeline matching the encoder latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_o <= 1'b0;
            enc_data_o  <= '0;
            id_s1       <= '0;
            id_valid_d1 <= 1'b0;
            id_d1       <= '0;
            last_grant  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            enc_valid_o <= handshake;
            if (handshake) begin
                enc_data_o <= req_data_arr[grant_idx];
                id_s1      <= grant_idx;
                last_grant <= grant_idx;
            end
            id_valid_d1 <= enc_valid_o;
            id_d1       <= id_s1;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid_o & out_ready_i;
    assign push_ok   = enc_valid_i & (~fifo_full | pop);
    assign overflow  = enc_valid_i & fifo_full & ~pop;
    assign orphan    = enc_valid_i & ~id_valid_d1;
    assign push_id   = id_valid_d1 ? id_d1 : '0;

    // FIFO pointers, occupancy and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_o      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (overflow || orphan) begin
                err_o <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written so no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= enc_data_i;
            mem_crc[wr_ptr]  <= enc_checksum_i;
            mem_id[wr_ptr]   <= push_id;
        end
    end

    assign out_valid_o = (fifo_count != '0);
    assign out_data_o  = mem_data[rd_ptr];
    assign out_crc_o   = mem_crc[rd_ptr];
    assign out_id_o    = mem_id[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_urp_pcie_crc32_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_urp_pcie_crc32_arb
// Description : Self-checking bench for urp_pcie_crc32_arb with a CRC32
//               encoder model, a queue-based reference model, a vector table
//               and hand-written corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_urp_pcie_crc32_arb;

    localparam int NR = 4;
    localparam int DW = 224;
    localparam int CW = 32;
    localparam int IW = 2;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_ready_o;
    logic              enc_valid_o;
    logic [DW-1:0]     enc_data_o;
    logic              enc_valid_i;
    logic [DW-1:0]     enc_data_i;
    logic [CW-1:0]     enc_checksum_i;
    logic              out_valid_o;
    logic [DW-1:0]     out_data_o;
    logic [CW-1:0]     out_crc_o;
    logic [IW-1:0]     out_id_o;
    logic              out_ready_i;
    logic              err_o;
    logic              enc_q_valid;
    logic              spurious;

    urp_pcie_crc32_arb #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .CRC_WIDTH(CW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .enc_valid_o(enc_valid_o), .enc_data_o(enc_data_o),
        .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i), .enc_checksum_i(enc_checksum_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_crc_o(out_crc_o),
        .out_id_o(out_id_o), .out_ready_i(out_ready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Reflected CRC32 (poly 0xEDB88320), bits consumed LSB first
    function automatic logic [31:0] crc32(input logic [DW-1:0] d);
        logic [31:0] c;
        logic        b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < DW; i++) begin
            b = c[0] ^ d[i];
            c = c >> 1;
            if (b) c = c ^ 32'hEDB8_8320;
        end
        return ~c;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Encoder model: one-cycle latency, same reset as the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_q_valid    <= 1'b0;
            enc_data_i     <= '0;
            enc_checksum_i <= '0;
        end else begin
            enc_q_valid    <= enc_valid_o;
            enc_data_i     <= enc_data_o;
            enc_checksum_i <= crc32(enc_data_o);
        end
    end
    assign enc_valid_i = enc_q_valid | spurious;

    // Reference model: beats in flight and beats queued for output
    typedef struct {
        logic [DW-1:0] data;
        int            id;
        int            age;
    } beat_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic          ordy;
        logic [NR-1:0] exp_ready;
        logic          exp_ov;
    } vec_t;

    beat_t pend[$];
    beat_t fq[$];
    int    last_grant;
    int    exp_idx;
    int    n_chk;
    int    n_fail;
    vec_t  tbl [11];

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fq.delete();
        last_grant = NR - 1;
    endtask

    // Sample at the falling edge and compare against the model
    task automatic cycle_check(input bit model_on);
        int            credits;
        logic [NR-1:0] er;
        @(negedge clk);
        credits = fq.size() + pend.size();
        exp_idx = -1;
        if (credits < FD) begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (last_grant + k) % NR;
                if (exp_idx < 0 && req_valid_i[idx]) exp_idx = idx;
            end
        end
        er = '0;
        if (exp_idx >= 0) er[exp_idx] = 1'b1;
        if (model_on) begin
            chk("req_ready", 256'(req_ready_o), 256'(er));
            chk("out_valid", 256'(out_valid_o), 256'(fq.size() != 0));
            if (fq.size() != 0) begin
                chk("out_data", 256'(out_data_o), 256'(fq[0].data));
                chk("out_crc", 256'(out_crc_o), 256'(crc32(fq[0].data)));
                chk("out_id", 256'(out_id_o), 256'(fq[0].id));
            end
            chk("err", 256'(err_o), 256'(0));
        end
    endtask

    // Apply this cycle's transfers to the model at the rising edge
    task automatic cycle_advance();
        bit    do_pop;
        beat_t b;
        do_pop = (fq.size() != 0) && out_ready_i;
        @(posedge clk);
        if (do_pop) void'(fq.pop_front());
        if (pend.size() != 0 && pend[0].age == 1) begin
            fq.push_back(pend[0]);
            void'(pend.pop_front());
        end
        foreach (pend[i]) pend[i].age++;
        if (exp_idx >= 0) begin
            b.data = req_data_i[exp_idx*DW +: DW];
            b.id   = exp_idx;
            b.age  = 0;
            pend.push_back(b);
            last_grant = exp_idx;
        end
        #1;
    endtask

    task automatic cycle();
        cycle_check(1'b1);
        cycle_advance();
    endtask

    task automatic rand_inputs(input bit all_valid);
        for (int i = 0; i < NR; i++) req_data_i[i*DW +: DW] = rand_data();
        req_valid_i = all_valid ? '1 : NR'($urandom);
    endtask

    // Asynchronous reset; outputs must drop without waiting for a clock
    task automatic do_reset();
        spurious = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_req_ready", 256'(req_ready_o), 256'(0));
        chk("rst_enc_valid", 256'(enc_valid_o), 256'(0));
        chk("rst_enc_data", 256'(enc_data_o), 256'(0));
        chk("rst_out_valid", 256'(out_valid_o), 256'(0));
        chk("rst_err", 256'(err_o), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        n_chk       = 0;
        n_fail      = 0;
        spurious    = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        out_ready_i = 1'b0;
        model_reset();

        // Backpressure vectors: four credits, then one pop frees one grant
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b0};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b1};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0001, 1'b1};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            rand_inputs(1'b1);
            req_valid_i = tbl[i].valid;
            out_ready_i = tbl[i].ordy;
            cycle_check(1'b1);
            chk("tbl_ready", 256'(req_ready_o), 256'(tbl[i].exp_ready));
            chk("tbl_out_valid", 256'(out_valid_o), 256'(tbl[i].exp_ov));
            cycle_advance();
        end
        req_valid_i = '0;
        out_ready_i = 1'b1;
        repeat (8) cycle();

        // Single beat from requester 0: three-cycle latency
        do_reset();
        d = rand_data();
        req_data_i[0 +: DW] = d;
        req_valid_i = 4'b0001;
        out_ready_i = 1'b1;
        for (int t = 0; t < 5; t++) begin
            cycle_check(1'b1);
            if (t == 0) chk("single_grant", 256'(req_ready_o), 256'(4'b0001));
            if (t == 1 || t == 2) chk("single_early", 256'(out_valid_o), 256'(0));
            if (t == 3) begin
                chk("single_valid", 256'(out_valid_o), 256'(1));
                chk("single_data", 256'(out_data_o), 256'(d));
                chk("single_crc", 256'(out_crc_o), 256'(crc32(d)));
                chk("single_id", 256'(out_id_o), 256'(0));
                chk("single_err", 256'(err_o), 256'(0));
            end
            cycle_advance();
            req_valid_i = '0;
        end

        // Fairness: all requesters valid, full rate
        do_reset();
        out_ready_i = 1'b1;
        for (int k = 0; k < 11; k++) begin
            rand_inputs(1'b1);
            if (k >= 8) req_valid_i = '0;
            cycle_check(1'b1);
            if (k < 8) chk("fair_grant", 256'(req_ready_o), 256'(1) << (k % 4));
            if (k >= 3) begin
                chk("fair_out_valid", 256'(out_valid_o), 256'(1));
                chk("fair_out_id", 256'(out_id_o), 256'((k - 3) % 4));
            end
            cycle_advance();
        end

        // Full FIFO with out_ready toggling: simultaneous push and pop
        do_reset();
        for (int k = 0; k < 40; k++) begin
            rand_inputs(1'b1);
            out_ready_i = (k >= 8) ? k[0] : 1'b0;
            cycle();
        end
        chk("full_err", 256'(err_o), 256'(0));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            rand_inputs(1'b0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset with beats in flight
        req_valid_i = '1;
        out_ready_i = 1'b1;
        #2;
        do_reset();
        cycle_check(1'b1);
        chk("post_rst_grant", 256'(req_ready_o), 256'(4'b0001));
        chk("post_rst_out_valid", 256'(out_valid_o), 256'(0));
        cycle_advance();
        for (int k = 0; k < 100; k++) begin
            rand_inputs(1'b0);
            out_ready_i = ($urandom_range(0, 1) != 0);
            cycle();
        end

        // Spurious encoder result while idle: sticky error, entry with ID 0
        do_reset();
        req_valid_i = '0;
        out_ready_i = 1'b0;
        @(negedge clk);
        chk("spur_err_before", 256'(err_o), 256'(0));
        @(posedge clk);
        #1;
        spurious = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("spur_err_sticky", 256'(err_o), 256'(1));
            chk("spur_out_valid", 256'(out_valid_o), 256'(1));
            chk("spur_out_id", 256'(out_id_o), 256'(0));
            @(posedge clk);
            #1;
        end
        do_reset();
        @(negedge clk);
        chk("spur_err_cleared", 256'(err_o), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
